// File: rtl/dual_port_memory_if.sv
// Request/response bus for dual_port_memory: a read-only fetch port (i_*)
// and a read/write data port with byte enables (d_*).
//   master : drives requests (core fetch/LSU side)
//   slave  : the memory, drives ready/rvalid/rdata/err
interface dual_port_memory_if #(
   parameter int XLEN = 32
);
   logic              i_req;
   logic [XLEN-1:0]   i_addr;
   logic              i_ready;
   logic              i_rvalid;
   logic [XLEN-1:0]   i_rdata;
   logic              i_err;

   logic              d_req;
   logic              d_we;
   logic [XLEN/8-1:0] d_be;
   logic [XLEN-1:0]   d_addr;
   logic [XLEN-1:0]   d_wdata;
   logic              d_ready;
   logic              d_rvalid;
   logic [XLEN-1:0]   d_rdata;
   logic              d_err;

   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
      input  i_ready, i_rvalid, i_rdata, i_err,
      input  d_ready, d_rvalid, d_rdata, d_err
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
      output i_ready, i_rvalid, i_rdata, i_err,
      output d_ready, d_rvalid, d_rdata, d_err
   );
endinterface

// File: rtl/dual_port_memory.sv
// Byte-addressed word memory with an instruction-fetch port (read-only) and
// a data port (read/write, byte enables). Each port has its own wait-state
// count, registered read data and an error response for misaligned or
// out-of-range addresses.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (array contents are not reset)
//   bus   : dual_port_memory_if.slave (i_* fetch port, d_* data port)

// Per-port handshake sequencer.
//   state  | meaning
//   IDLE   | no response pending, ready high
//   WAIT   | counting wait states, ready low, requests ignored
//   RESP   | rvalid high this cycle, may accept the next request
module dual_port_memory_fsm #(
   parameter int WAIT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   output logic ready,
   output logic accept,
   output logic in_wait,
   output logic load,
   output logic rvalid
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   logic [1:0] state;
   logic [3:0] cnt;

   assign ready   = (state != S_WAIT);
   assign accept  = req && ready;
   assign in_wait = (state == S_WAIT);
   assign rvalid  = (state == S_RESP);
   // Response register loads on the edge that enters RESP.
   assign load    = (in_wait && (cnt == 4'd0)) || (accept && (WAIT == 0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         case (state)
            S_WAIT: begin
               if (cnt == 4'd0) state <= S_RESP;
               else             cnt   <= cnt - 4'd1;
            end
            default: begin
               if (accept) begin
                  if (WAIT == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end
endmodule

module dual_port_memory #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 1024,
   parameter int I_WAIT = 0,
   parameter int D_WAIT = 0
) (
   input logic               clk,
   input logic               rst_n,
   dual_port_memory_if.slave bus
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int HI    = OFF_W + IDX_W;
   localparam logic [XLEN-1:0] OFF_MASK = XLEN'((64'd1 << OFF_W) - 64'd1);

   logic [XLEN-1:0] mem [DEPTH];

   function automatic logic addr_bad(input logic [XLEN-1:0] a);
      return ((a & OFF_MASK) != '0) || ((a >> HI) != '0);
   endfunction

   logic             i_accept, i_in_wait, i_load, i_rvalid;
   logic             d_accept, d_in_wait, d_load, d_rvalid;
   logic             i_ready, d_ready;
   logic [IDX_W-1:0] i_idx, d_idx;
   logic             i_bad, d_bad;
   logic [XLEN-1:0]  i_fresh, d_fresh;
   logic [XLEN-1:0]  i_cap_data, d_cap_data, i_rdata_q, d_rdata_q;
   logic             i_cap_err, d_cap_err, i_err_q, d_err_q;

   dual_port_memory_fsm #(.WAIT(I_WAIT)) u_i_fsm (
      .clk(clk), .rst_n(rst_n), .req(bus.i_req), .ready(i_ready),
      .accept(i_accept), .in_wait(i_in_wait), .load(i_load), .rvalid(i_rvalid)
   );

   dual_port_memory_fsm #(.WAIT(D_WAIT)) u_d_fsm (
      .clk(clk), .rst_n(rst_n), .req(bus.d_req), .ready(d_ready),
      .accept(d_accept), .in_wait(d_in_wait), .load(d_load), .rvalid(d_rvalid)
   );

   assign i_idx   = bus.i_addr[HI-1:OFF_W];
   assign d_idx   = bus.d_addr[HI-1:OFF_W];
   assign i_bad   = addr_bad(bus.i_addr);
   assign d_bad   = addr_bad(bus.d_addr);
   // Array is read before the same-edge write lands, giving read-before-write
   // on a fetch/data collision. Writes and errors return zero data.
   assign i_fresh = i_bad ? '0 : mem[i_idx];
   assign d_fresh = (d_bad || bus.d_we) ? '0 : mem[d_idx];

   // rst_n gate keeps a request held during reset from writing the array.
   always_ff @(posedge clk) begin
      if (rst_n && d_accept && bus.d_we && !d_bad) begin
         for (int k = 0; k < NB; k++) begin
            if (bus.d_be[k]) mem[d_idx][8*k +: 8] <= bus.d_wdata[8*k +: 8];
         end
      end
   end

   // Read data is captured at accept and only moved to the output register
   // when RESP is entered, so rdata stays stable while rvalid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_cap_data <= '0;
         i_cap_err  <= 1'b0;
         i_rdata_q  <= '0;
         i_err_q    <= 1'b0;
         d_cap_data <= '0;
         d_cap_err  <= 1'b0;
         d_rdata_q  <= '0;
         d_err_q    <= 1'b0;
      end else begin
         if (i_accept) begin
            i_cap_data <= i_fresh;
            i_cap_err  <= i_bad;
         end
         if (i_load) begin
            i_rdata_q <= i_in_wait ? i_cap_data : i_fresh;
            i_err_q   <= i_in_wait ? i_cap_err  : i_bad;
         end
         if (d_accept) begin
            d_cap_data <= d_fresh;
            d_cap_err  <= d_bad;
         end
         if (d_load) begin
            d_rdata_q <= d_in_wait ? d_cap_data : d_fresh;
            d_err_q   <= d_in_wait ? d_cap_err  : d_bad;
         end
      end
   end

   assign bus.i_ready  = i_ready;
   assign bus.i_rvalid = i_rvalid;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.i_err    = i_err_q;
   assign bus.d_ready  = d_ready;
   assign bus.d_rvalid = d_rvalid;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.d_err    = d_err_q;
endmodule

// File: tb/tb_dual_port_memory.sv
module tb_dual_port_memory;
   typedef struct {
      logic        err;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_c = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_mis = 0;

   exp_t        q [6][$];
   exp_t        got;
   logic        mon_v [6];
   logic        mon_e [6];
   logic [31:0] mon_d [6];
   string       pname [6] = '{"a_fetch", "a_data", "b_fetch", "b_data", "c_fetch", "c_data"};

   dual_port_memory_if #(.XLEN(32)) ifa ();
   dual_port_memory_if #(.XLEN(32)) ifb ();
   dual_port_memory_if #(.XLEN(32)) ifc ();

   dual_port_memory #(.XLEN(32), .DEPTH(1024), .I_WAIT(0), .D_WAIT(0))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   dual_port_memory #(.XLEN(32), .DEPTH(1024), .I_WAIT(0), .D_WAIT(3))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   dual_port_memory #(.XLEN(32), .DEPTH(1024), .I_WAIT(0), .D_WAIT(5))
      dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      mon_v[0] = ifa.i_rvalid; mon_e[0] = ifa.i_err; mon_d[0] = ifa.i_rdata;
      mon_v[1] = ifa.d_rvalid; mon_e[1] = ifa.d_err; mon_d[1] = ifa.d_rdata;
      mon_v[2] = ifb.i_rvalid; mon_e[2] = ifb.i_err; mon_d[2] = ifb.i_rdata;
      mon_v[3] = ifb.d_rvalid; mon_e[3] = ifb.d_err; mon_d[3] = ifb.d_rdata;
      mon_v[4] = ifc.i_rvalid; mon_e[4] = ifc.i_err; mon_d[4] = ifc.i_rdata;
      mon_v[5] = ifc.d_rvalid; mon_e[5] = ifc.d_err; mon_d[5] = ifc.d_rdata;
   end

   // Scoreboard monitor: every response must match the head of its port queue,
   // including the cycle on which it appears.
   always @(negedge clk) begin
      for (int p = 0; p < 6; p++) begin
         if (mon_v[p] === 1'b1) begin
            n_vec++;
            if (q[p].size() == 0) begin
               n_mis++;
               $display("FAIL %s unexpected rvalid at cycle %0d: got err=%b data=%h, required no response",
                        pname[p], cyc, mon_e[p], mon_d[p]);
            end else begin
               got = q[p].pop_front();
               if (mon_e[p] !== got.err || mon_d[p] !== got.data || cyc != got.cyc) begin
                  n_mis++;
                  $display("FAIL %s response: got err=%b data=%h cycle=%0d, required err=%b data=%h cycle=%0d",
                           pname[p], mon_e[p], mon_d[p], cyc, got.err, got.data, got.cyc);
               end
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      ifa.i_req = 1'b0; ifa.d_req = 1'b0;
      ifb.i_req = 1'b0; ifb.d_req = 1'b0;
      ifc.i_req = 1'b0; ifc.d_req = 1'b0;
   endtask

   task automatic fetch(input int u, input logic [31:0] a, input logic e,
                        input logic [31:0] d, input int w);
      exp_t x;
      x.err = e; x.data = d; x.cyc = cyc + 1 + w;
      q[2*u].push_back(x);
      case (u)
         0: begin ifa.i_req = 1'b1; ifa.i_addr = a; end
         1: begin ifb.i_req = 1'b1; ifb.i_addr = a; end
         default: begin ifc.i_req = 1'b1; ifc.i_addr = a; end
      endcase
   endtask

   task automatic dreq(input int u, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd, input logic push,
                       input logic e, input logic [31:0] d, input int w);
      exp_t x;
      x.err = e; x.data = d; x.cyc = cyc + 1 + w;
      if (push) q[2*u+1].push_back(x);
      case (u)
         0: begin ifa.d_req = 1'b1; ifa.d_we = we; ifa.d_be = be; ifa.d_addr = a; ifa.d_wdata = wd; end
         1: begin ifb.d_req = 1'b1; ifb.d_we = we; ifb.d_be = be; ifb.d_addr = a; ifb.d_wdata = wd; end
         default: begin ifc.d_req = 1'b1; ifc.d_we = we; ifc.d_be = be; ifc.d_addr = a; ifc.d_wdata = wd; end
      endcase
   endtask

   initial begin
      clr();
      ifa.i_addr = '0; ifa.d_we = 1'b0; ifa.d_be = '0; ifa.d_addr = '0; ifa.d_wdata = '0;
      ifb.i_addr = '0; ifb.d_we = 1'b0; ifb.d_be = '0; ifb.d_addr = '0; ifb.d_wdata = '0;
      ifc.i_addr = '0; ifc.d_we = 1'b0; ifc.d_be = '0; ifc.d_addr = '0; ifc.d_wdata = '0;
      repeat (3) tick();

      check("a_i_ready_rst",  {31'd0, ifa.i_ready},  32'd1);
      check("a_d_ready_rst",  {31'd0, ifa.d_ready},  32'd1);
      check("a_i_rvalid_rst", {31'd0, ifa.i_rvalid}, 32'd0);
      check("a_d_rvalid_rst", {31'd0, ifa.d_rvalid}, 32'd0);
      check("a_i_rdata_rst",  ifa.i_rdata, 32'd0);
      check("a_d_rdata_rst",  ifa.d_rdata, 32'd0);
      check("a_err_rst",      {30'd0, ifa.i_err, ifa.d_err}, 32'd0);
      check("c_d_ready_rst",  {31'd0, ifc.d_ready}, 32'd1);
      rst_n = 1'b1;
      rst_c = 1'b1;
      tick();

      // Port A: zero wait states, back-to-back traffic.
      dreq(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 0);
      tick(); clr();
      fetch(0, 32'h10, 1'b0, 32'hDEADBEEF, 0);
      dreq(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b1, 1'b0, 32'h0, 0);
      tick(); clr();
      dreq(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b1, 1'b0, 32'h0, 0);
      tick(); clr();
      dreq(0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h11BB33DD, 0);
      tick(); clr();
      dreq(0, 1'b1, 4'hF, 32'h13, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 0);
      tick(); clr();
      dreq(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 0);
      fetch(0, 32'h1000, 1'b1, 32'h0, 0);
      tick(); clr();
      dreq(0, 1'b1, 4'hF, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0, 0);
      fetch(0, 32'h12, 1'b1, 32'h0, 0);
      tick(); clr();
      fetch(0, 32'h40, 1'b0, 32'h0, 0);
      dreq(0, 1'b1, 4'hF, 32'h40, 32'h55, 1'b1, 1'b0, 32'h0, 0);
      tick(); clr();
      fetch(0, 32'h40, 1'b0, 32'h55, 0);
      dreq(0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 0);
      tick(); clr();
      dreq(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 0);
      tick(); clr();
      dreq(0, 1'b0, 4'h0, 32'h1000, 32'h0, 1'b1, 1'b1, 32'h0, 0);
      tick(); clr();
      repeat (3) tick();

      // Port B: three wait states; a request held through WAIT is taken in RESP.
      dreq(1, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 3);
      tick();
      ifb.d_we = 1'b0; ifb.d_addr = 32'h0;
      for (int k = 0; k < 3; k++) begin
         check("b_d_ready_wait", {31'd0, ifb.d_ready}, 32'd0);
         tick();
      end
      check("b_d_ready_resp", {31'd0, ifb.d_ready}, 32'd1);
      dreq(1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 3);
      tick(); clr();
      repeat (6) tick();

      // Port C: five wait states, reset while a write is waiting.
      dreq(2, 1'b1, 4'hF, 32'h8, 32'h12345678, 1'b1, 1'b0, 32'h0, 5);
      tick(); clr();
      repeat (7) tick();
      dreq(2, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h12345678, 5);
      tick(); clr();
      repeat (7) tick();
      dreq(2, 1'b1, 4'hF, 32'hC, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 5);
      tick(); clr();
      tick();
      check("c_d_ready_wait", {31'd0, ifc.d_ready}, 32'd0);
      rst_c = 1'b0;
      #1;
      check("c_d_ready_rst",  {31'd0, ifc.d_ready},  32'd1);
      check("c_d_rvalid_rst", {31'd0, ifc.d_rvalid}, 32'd0);
      check("c_d_rdata_rst",  ifc.d_rdata, 32'd0);
      check("c_d_err_rst",    {31'd0, ifc.d_err}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_c = 1'b1;
      repeat (9) tick();
      dreq(2, 1'b0, 4'h0, 32'hC, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 5);
      tick(); clr();
      repeat (7) tick();
      dreq(2, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h12345678, 5);
      tick(); clr();
      repeat (8) tick();

      for (int p = 0; p < 6; p++) begin
         n_vec++;
         if (q[p].size() != 0) begin
            n_mis++;
            $display("FAIL %s missing responses: got %0d outstanding, required 0", pname[p], q[p].size());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
